// File: rtl/exp_taylor_pipe.sv
// Fully pipelined fixed-point exp(x): truncated Taylor series at 0, one stage per term,
// reciprocal-factorial coefficients (no divider), clamped and flagged output.
module exp_taylor_pipe #(
    parameter int    W          = 16,
    parameter int    FRAC       = 10,
    parameter int    N_TERMS    = 4,
    parameter string COEFF_FILE = "../data_file/exp_coeff.hex"
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_sat
);

    localparam int IW = 2 * W + 8;
    localparam int PW = IW + W + 1;

    typedef logic signed [IW-1:0]      iw_t;
    typedef logic signed [PW-1:0]      pw_t;
    typedef logic [N_TERMS-1:0][W-1:0] coeff_tbl_t;

    // c_k = round(2^FRAC / k!), the same values as the COEFF_FILE image, built at
    // elaboration so the read-only table needs no file access in the build flow.
    function automatic coeff_tbl_t coeff_table();
        coeff_tbl_t tbl;
        longint     fact;
        tbl  = '0;
        fact = 1;
        for (int k = 0; k < N_TERMS; k++) begin
            if (k > 1) fact = fact * longint'(k);
            tbl[k] = W'(((longint'(1) <<< (FRAC + 1)) + fact) / (2 * fact));
        end
        return tbl;
    endfunction

    localparam coeff_tbl_t COEFF = coeff_table();

    if (COEFF_FILE == "") begin : g_coeff_builtin
    end

    localparam pw_t IW_MAX  = (pw_t'(1) <<< (IW - 1)) - pw_t'(1);
    localparam pw_t IW_MIN  = -(pw_t'(1) <<< (IW - 1));
    localparam iw_t OUT_MAX = (iw_t'(1) <<< (W - 1)) - iw_t'(1);

    function automatic logic out_of_range(input pw_t v);
        return (v > IW_MAX) || (v < IW_MIN);
    endfunction

    function automatic iw_t clip(input pw_t v);
        if (v > IW_MAX) return iw_t'(IW_MAX);
        if (v < IW_MIN) return iw_t'(IW_MIN);
        return iw_t'(v);
    endfunction

    logic signed [W-1:0] x_q     [N_TERMS];
    iw_t                 p_q     [N_TERMS];
    iw_t                 acc_q   [N_TERMS];
    logic                ovf_q   [N_TERMS];
    logic                vld_q   [N_TERMS];

    iw_t                 p_nxt   [1:N_TERMS-1];
    iw_t                 acc_nxt [1:N_TERMS-1];
    logic                ovf_nxt [1:N_TERMS-1];
    pw_t                 p_prod;
    pw_t                 acc_sum;

    logic                adv;
    logic [W-1:0]        data_nxt;
    logic                sat_nxt;

    // Handshake: a transfer happens when valid && ready in the same cycle. The whole
    // pipe advances together on adv; when the output is held, every stage holds too.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    always_comb begin
        p_prod  = '0;
        acc_sum = '0;
        for (int k = 1; k < N_TERMS; k++) begin
            p_prod     = (pw_t'(p_q[k-1]) * pw_t'(x_q[k-1])) >>> FRAC;
            acc_sum    = pw_t'(acc_q[k-1]) + ((pw_t'(p_q[k-1]) * pw_t'(COEFF[k])) >>> FRAC);
            p_nxt[k]   = clip(p_prod);
            acc_nxt[k] = clip(acc_sum);
            ovf_nxt[k] = ovf_q[k-1] | out_of_range(p_prod) | out_of_range(acc_sum);
        end
    end

    always_comb begin
        data_nxt = '0;
        sat_nxt  = 1'b0;
        if (acc_q[N_TERMS-1] < 0) begin
            data_nxt = '0;
            sat_nxt  = 1'b1;
        end else if (acc_q[N_TERMS-1] > OUT_MAX) begin
            data_nxt = OUT_MAX[W-1:0];
            sat_nxt  = 1'b1;
        end else begin
            data_nxt = acc_q[N_TERMS-1][W-1:0];
            sat_nxt  = ovf_q[N_TERMS-1];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int k = 0; k < N_TERMS; k++) begin
                x_q[k]   <= '0;
                p_q[k]   <= '0;
                acc_q[k] <= '0;
                ovf_q[k] <= 1'b0;
                vld_q[k] <= 1'b0;
            end
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else if (adv) begin
            x_q[0]   <= $signed(in_data);
            p_q[0]   <= iw_t'($signed(in_data));
            acc_q[0] <= iw_t'(COEFF[0]);
            ovf_q[0] <= 1'b0;
            vld_q[0] <= in_valid;
            for (int k = 1; k < N_TERMS; k++) begin
                x_q[k]   <= x_q[k-1];
                p_q[k]   <= p_nxt[k];
                acc_q[k] <= acc_nxt[k];
                ovf_q[k] <= ovf_nxt[k];
                vld_q[k] <= vld_q[k-1];
            end
            out_valid <= vld_q[N_TERMS-1];
            out_data  <= data_nxt;
            out_sat   <= sat_nxt;
        end
    end

endmodule

// File: tb/tb_exp_taylor_pipe.sv
// Self-checking bench for exp_taylor_pipe: directed series values, clamps, backpressure,
// reset flush and random streams against a plain-arithmetic Taylor reference.
module tb_exp_taylor_pipe;

    localparam int     W       = 16;
    localparam int     FRAC    = 10;
    localparam int     N_TERMS = 4;
    localparam longint IW_MAX  = (longint'(1) <<< 39) - 1;
    localparam longint IW_MIN  = -(longint'(1) <<< 39);

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = 16'h0000;
    logic        out_ready = 1'b1;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_sat;

    int          checks = 0;
    int          errors = 0;
    longint      coef [4] = '{1024, 1024, 512, 171};
    logic [16:0] exp_q [$];

    exp_taylor_pipe #(.W(W), .FRAC(FRAC), .N_TERMS(N_TERMS)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat)
    );

    always #5 CLK = ~CLK;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // exp(x) ~ sum_k x^k/k!, evaluated term by term with floor shifts and 40-bit saturation.
    function automatic logic [16:0] ref_exp(input logic [15:0] xin);
        longint x, p, acc, pn;
        logic   ovf;
        x   = longint'($signed(xin));
        p   = x;
        acc = coef[0];
        ovf = 1'b0;
        for (int k = 1; k < N_TERMS; k++) begin
            acc = acc + ((p * coef[k]) >>> FRAC);
            pn  = (p * x) >>> FRAC;
            if (acc > IW_MAX) begin acc = IW_MAX; ovf = 1'b1; end
            if (acc < IW_MIN) begin acc = IW_MIN; ovf = 1'b1; end
            if (pn > IW_MAX) begin pn = IW_MAX; ovf = 1'b1; end
            if (pn < IW_MIN) begin pn = IW_MIN; ovf = 1'b1; end
            p = pn;
        end
        if (acc < 0) return {1'b1, 16'h0000};
        if (acc > 32767) return {1'b1, 16'h7FFF};
        return {ovf, acc[15:0]};
    endfunction

    task automatic test_reset();
        int          first;
        logic        stale;
        logic [15:0] d;
        logic        s;
        RST = 1'b1; in_valid = 1'b1; in_data = 16'h0400; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            checks++;
            if (out_valid !== 1'b0 || out_data !== 16'h0000 || out_sat !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs cyc %0d: valid=%b data=%h sat=%b, required 0 0000 0",
                         i, out_valid, out_data, out_sat);
            end
        end
        @(posedge CLK); #1;
        RST = 1'b0; in_valid = 1'b0;
        stale = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            if (out_valid === 1'b1) stale = 1'b1;
        end
        checks++;
        if (stale !== 1'b0) begin
            errors++;
            $display("FAIL reset_ignored_input: out_valid seen=%b, required 0", stale);
        end
        @(posedge CLK); #1;
        in_valid = 1'b1; in_data = 16'h0000;
        @(posedge CLK); #1;
        in_valid = 1'b0;
        first = -1; d = '0; s = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge CLK);
            if (out_valid === 1'b1 && first < 0) begin
                first = n; d = out_data; s = out_sat;
            end
        end
        checks++;
        if (first != 5) begin
            errors++;
            $display("FAIL reset_latency: first out_valid after %0d cycles, required 5", first);
        end
        checks++;
        if (d !== 16'd1024 || s !== 1'b0) begin
            errors++;
            $display("FAIL exp_zero: data=%0d sat=%b, required 1024 0", d, s);
        end
    endtask

    task automatic test_streaming();
        int xs [3] = '{1024, -1024, 2048};
        int ys [3] = '{2731, 341, 6488};
        int got, prev;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = 16'(xs[i]);
            @(posedge CLK); #1;
        end
        in_valid = 1'b0;
        got = 0; prev = -1;
        for (int n = 0; n < 16 && got < 3; n++) begin
            @(negedge CLK);
            if (out_valid === 1'b1) begin
                checks++;
                if (out_data !== 16'(ys[got]) || out_sat !== 1'b0) begin
                    errors++;
                    $display("FAIL stream_value %0d: data=%0d sat=%b, required %0d 0",
                             got, out_data, out_sat, ys[got]);
                end
                if (prev >= 0) begin
                    checks++;
                    if (n != prev + 1) begin
                        errors++;
                        $display("FAIL stream_gap %0d: cycle %0d, required %0d", got, n, prev + 1);
                    end
                end
                prev = n;
                got++;
            end
        end
        checks++;
        if (got != 3) begin
            errors++;
            $display("FAIL stream_count: got %0d, required 3", got);
        end
    endtask

    task automatic test_saturation();
        logic [15:0] xs [2] = '{16'h7FFF, 16'hE000};
        logic [16:0] ys [2] = '{{1'b1, 16'h7FFF}, {1'b1, 16'h0000}};
        int got;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_data = xs[i];
            @(posedge CLK); #1;
        end
        in_valid = 1'b0;
        got = 0;
        for (int n = 0; n < 16 && got < 2; n++) begin
            @(negedge CLK);
            if (out_valid === 1'b1) begin
                checks++;
                if ({out_sat, out_data} !== ys[got]) begin
                    errors++;
                    $display("FAIL saturation %0d: sat=%b data=%h, required sat=%b data=%h",
                             got, out_sat, out_data, ys[got][16], ys[got][15:0]);
                end
                got++;
            end
        end
        checks++;
        if (got != 2) begin
            errors++;
            $display("FAIL saturation_count: got %0d, required 2", got);
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] samples [8];
        int          sent, got, first, stall_seen, extra;
        logic [15:0] held;
        logic        held_v, acc_ok;
        logic [16:0] e;
        for (int i = 0; i < 8; i++)
            samples[i] = (i % 3 == 0) ? 16'($urandom) : 16'($urandom_range(0, 8191) - 4096);
        exp_q.delete();
        sent = 0; got = 0; first = -1; stall_seen = 0; held = '0; held_v = 1'b0;
        fork
            begin
                @(posedge CLK); #1;
                in_valid = 1'b1; in_data = samples[0];
                for (int t = 0; t < 100 && sent < 8; t++) begin
                    @(negedge CLK);
                    acc_ok = in_ready;
                    @(posedge CLK); #1;
                    if (acc_ok === 1'b1) begin
                        exp_q.push_back(ref_exp(samples[sent]));
                        sent++;
                    end
                    if (sent < 8) in_data = samples[sent];
                    else in_valid = 1'b0;
                end
                in_valid = 1'b0;
            end
            begin
                for (int cyc = 0; cyc < 80 && got < 8; cyc++) begin
                    @(posedge CLK); #1;
                    out_ready = !(first >= 0 && cyc >= first + 2 && cyc < first + 6);
                    @(negedge CLK);
                    if (out_valid === 1'b1 && first < 0) first = cyc;
                    if (out_valid === 1'b1 && out_ready == 1'b0) begin
                        stall_seen++;
                        checks++;
                        if (in_ready !== 1'b0) begin
                            errors++;
                            $display("FAIL stall_in_ready cyc %0d: in_ready=%b, required 0", cyc, in_ready);
                        end
                        if (held_v) begin
                            checks++;
                            if (out_data !== held) begin
                                errors++;
                                $display("FAIL stall_hold cyc %0d: data=%h, required %h", cyc, out_data, held);
                            end
                        end
                        held = out_data; held_v = 1'b1;
                    end else begin
                        held_v = 1'b0;
                    end
                    if (out_valid === 1'b1 && out_ready == 1'b1) begin
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL bp_extra: unexpected output data=%h", out_data);
                        end else begin
                            e = exp_q.pop_front();
                            if ({out_sat, out_data} !== e) begin
                                errors++;
                                $display("FAIL bp_value %0d: sat=%b data=%h, required sat=%b data=%h",
                                         got, out_sat, out_data, e[16], e[15:0]);
                            end
                        end
                        got++;
                    end
                end
                out_ready = 1'b1;
            end
        join
        checks++;
        if (got != 8 || sent != 8) begin
            errors++;
            $display("FAIL bp_count: sent %0d got %0d, required 8 8", sent, got);
        end
        checks++;
        if (stall_seen != 4) begin
            errors++;
            $display("FAIL bp_stall_cycles: %0d, required 4", stall_seen);
        end
        extra = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            if (out_valid === 1'b1) extra++;
        end
        checks++;
        if (extra != 0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL bp_drain: extra outputs %0d, pending %0d, required 0 0", extra, exp_q.size());
        end
    endtask

    task automatic test_random_stream();
        logic [15:0] x;
        int          got;
        logic [16:0] e;
        exp_q.delete();
        got = 0;
        fork
            begin
                for (int i = 0; i < 16; i++) begin
                    x = 16'($urandom);
                    in_valid = 1'b1; in_data = x;
                    exp_q.push_back(ref_exp(x));
                    @(posedge CLK); #1;
                end
                in_valid = 1'b0;
            end
            begin
                for (int n = 0; n < 60 && got < 16; n++) begin
                    @(negedge CLK);
                    if (out_valid === 1'b1) begin
                        checks++;
                        e = (exp_q.size() != 0) ? exp_q.pop_front() : 17'h1FFFF;
                        if ({out_sat, out_data} !== e) begin
                            errors++;
                            $display("FAIL random_value %0d: sat=%b data=%h, required sat=%b data=%h",
                                     got, out_sat, out_data, e[16], e[15:0]);
                        end
                        got++;
                    end
                end
            end
        join
        checks++;
        if (got != 16) begin
            errors++;
            $display("FAIL random_count: got %0d, required 16", got);
        end
    endtask

    task automatic test_reset_flush();
        logic        stale;
        logic [15:0] x;
        logic [16:0] e;
        int          first;
        logic [16:0] seen;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = 16'($urandom_range(0, 4095));
            @(posedge CLK); #1;
        end
        in_valid = 1'b0;
        @(posedge CLK); #1;
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        @(negedge CLK);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_after_reset: out_valid=%b, required 0", out_valid);
        end
        stale = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            if (out_valid === 1'b1) stale = 1'b1;
        end
        checks++;
        if (stale !== 1'b0) begin
            errors++;
            $display("FAIL flush_stale: out_valid seen=%b, required 0", stale);
        end
        x = 16'($urandom_range(0, 6000) - 3000);
        e = ref_exp(x);
        @(posedge CLK); #1;
        in_valid = 1'b1; in_data = x;
        @(posedge CLK); #1;
        in_valid = 1'b0;
        first = -1; seen = '0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge CLK);
            if (out_valid === 1'b1 && first < 0) begin
                first = n; seen = {out_sat, out_data};
            end
        end
        checks++;
        if (first != 5 || seen !== e) begin
            errors++;
            $display("FAIL flush_recover: latency %0d sat=%b data=%h, required 5 sat=%b data=%h",
                     first, seen[16], seen[15:0], e[16], e[15:0]);
        end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_saturation();
        test_backpressure();
        test_random_stream();
        test_reset_flush();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
